gauss_filter_pipe: RTL and testbench

- Parametrised, pipelined successor to the 17-tap GFSK Gaussian pulse-shaping filter.
- Filters an upsampled bipolar bit stream (bit 1 -> +coef, bit 0 -> -coef) with a symmetric FIR of configurable length, runtime-writable half-coefficients, output scaling and saturation.
- Sits between the bit upsampler and the frequency/phase integrator in the BLE TX chain.
- Adds a valid/ready handshake and an automatic end-of-packet tail flush.

---
 rtl/gauss_filter_pipe.sv | 181 ++++++++++++++++++
 tb/tb_gauss_filter_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gauss_filter_pipe.sv
// Pipelined symmetric Gaussian FIR over a bipolar upsampled bit stream, with tail flush.
// Optional: define GAUSS_FILTER_SATURATE_EN to clamp the output instead of wrapping it.
module gauss_filter_pipe #(
    parameter int NUM_TAP   = 17,
    parameter int COEF_W    = 6,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tap_we,
    input  logic [4:0]               tap_addr,
    input  logic signed [COEF_W-1:0] tap_wdata,
    input  logic                     in_bit,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    output logic                     out_last
);
    localparam int C      = (NUM_TAP - 1) / 2;
    localparam int HIST_W = (NUM_TAP > 1) ? NUM_TAP - 1 : 1;
    localparam int SUM_W  = COEF_W + 5;
    localparam int EXT_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t                   state, state_nxt;
    logic [4:0]               flush_cnt, flush_cnt_nxt;
    logic [HIST_W-1:0]        hist, hist_nxt;
    logic signed [COEF_W-1:0] coef [0:C];
    logic [NUM_TAP-1:0]       tap_bits;

    logic                     bit_p0, vld_p0, last_p0;
    logic signed [SUM_W-1:0]  psum_lo_p0, psum_hi_p0;
    logic signed [SUM_W-1:0]  psum_lo_p1, psum_hi_p1;
    logic                     vld_p1, last_p1;
    logic signed [SUM_W-1:0]  sum_p1;
    logic signed [OUT_W-1:0]  data_p2;
    logic                     vld_p2, last_p2;

    function automatic logic signed [SUM_W-1:0] signed_term(
        input logic                     b,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [SUM_W-1:0] mag;
        mag = SUM_W'(c);
        return b ? mag : -mag;
    endfunction

    function automatic logic signed [OUT_W-1:0] reduce_sum(input logic signed [SUM_W-1:0] s);
        logic signed [EXT_W-1:0] x;
`ifdef GAUSS_FILTER_SATURATE_EN
        logic signed [EXT_W-1:0] hi, lo;
        x  = EXT_W'(s);
        hi = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
        lo = ~hi;
        if (x > hi)
            x = hi;
        else if (x < lo)
            x = lo;
`else
        x = EXT_W'(s);
`endif
        return x[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= C; i++) coef[i] <= '0;
        end else if (tap_we) begin
            for (int i = 0; i <= C; i++)
                if (tap_addr == 5'(i)) coef[i] <= tap_wdata;
        end
    end

    // Stage 0: sample selection (external input or flush injection of the last bit)
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        in_ready      = 1'b1;
        vld_p0        = 1'b0;
        last_p0       = 1'b0;
        bit_p0        = in_bit;
        case (state)
            FLUSH: begin
                in_ready      = 1'b0;
                vld_p0        = 1'b1;
                bit_p0        = hist[0];
                flush_cnt_nxt = flush_cnt - 5'd1;
                if (flush_cnt == 5'd1) begin
                    last_p0   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                if (in_valid) begin
                    vld_p0 = 1'b1;
                    if (!in_last) begin
                        state_nxt = RUN;
                    end else if (C == 0) begin
                        last_p0   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = FLUSH;
                        flush_cnt_nxt = 5'(C);
                    end
                end
            end
        endcase
    end

    always_comb begin
        tap_bits    = '0;
        tap_bits[0] = bit_p0;
        for (int k = 1; k < NUM_TAP; k++) tap_bits[k] = hist[k-1];
        hist_nxt    = '0;
        hist_nxt[0] = bit_p0;
        for (int i = 1; i < HIST_W; i++) hist_nxt[i] = hist[i-1];
    end

    // Folded symmetric taps: the upper half reuses the mirrored coefficient
    always_comb begin
        psum_lo_p0 = '0;
        psum_hi_p0 = '0;
        for (int k = 0; k <= C; k++)
            psum_lo_p0 = psum_lo_p0 + signed_term(tap_bits[k], coef[k]);
        for (int k = C + 1; k < NUM_TAP; k++)
            psum_hi_p0 = psum_hi_p0 + signed_term(tap_bits[k], coef[NUM_TAP-1-k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            hist      <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (vld_p0) hist <= hist_nxt;
        end
    end

    // Stage 1: registered partial sums
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_lo_p1 <= '0;
            psum_hi_p1 <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
            if (vld_p0) begin
                psum_lo_p1 <= psum_lo_p0;
                psum_hi_p1 <= psum_hi_p0;
            end
        end
    end

    assign sum_p1 = (psum_lo_p1 + psum_hi_p1) >>> OUT_SHIFT;

    // Stage 2: scaled, width-reduced output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2 <= '0;
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            if (vld_p1) data_p2 <= reduce_sum(sum_p1);
        end
    end

    assign out_data  = data_p2;
    assign out_valid = vld_p2;
    assign out_last  = last_p2;

endmodule

// File: tb/tb_gauss_filter_pipe.sv
// Scoreboard bench for gauss_filter_pipe: two 5-tap instances (8- and 5-bit outputs) share
// stimulus; a 1-tap instance covers the no-flush case.
module tb_gauss_filter_pipe;

    typedef struct packed {
        logic signed [15:0] val;
        logic               last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b1;
    logic              tap_we = 1'b0;
    logic [4:0]        tap_addr = '0;
    logic signed [5:0] tap_wdata = '0;
    logic              in_bit = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic              c_in_bit = 1'b0, c_in_valid = 1'b0, c_in_last = 1'b0;

    logic              in_ready_a, out_valid_a, out_last_a;
    logic signed [7:0] out_data_a;
    logic              in_ready_b, out_valid_b, out_last_b;
    logic signed [4:0] out_data_b;
    logic              in_ready_c, out_valid_c, out_last_c;
    logic signed [7:0] out_data_c;

    exp_t q_a[$], q_b[$], q_c[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_low_a = 0;
    int   ready_low_c = 0;

    gauss_filter_pipe #(.NUM_TAP(5), .COEF_W(6), .OUT_W(8), .OUT_SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
        .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_last(out_last_a));

    gauss_filter_pipe #(.NUM_TAP(5), .COEF_W(6), .OUT_W(5), .OUT_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
        .in_bit(in_bit), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_last(out_last_b));

    gauss_filter_pipe #(.NUM_TAP(1), .COEF_W(6), .OUT_W(8), .OUT_SHIFT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
        .in_bit(c_in_bit), .in_valid(c_in_valid), .in_last(c_in_last), .in_ready(in_ready_c),
        .out_data(out_data_c), .out_valid(out_valid_c), .out_last(out_last_c));

    // Expected 5-bit output from a full-precision sum
    function automatic int red5(input int s);
        int r;
`ifdef GAUSS_FILTER_SATURATE_EN
        r = (s > 15) ? 15 : ((s < -16) ? -16 : s);
`else
        r = s & 31;
        if (r > 15) r = r - 32;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic bad(input string name, input int got);
        checks++;
        errors++;
        $display("FAIL %s: got %0d, expected no event", name, got);
    endtask

    task automatic push_exp(input int e, input logic l);
        exp_t t;
        t.val = 16'(e); t.last = l; q_a.push_back(t);
        t.val = 16'(red5(e));      q_b.push_back(t);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!in_ready_a) ready_low_a++;
            if (!in_ready_c) ready_low_c++;
            if (out_valid_a) begin
                if (q_a.size() == 0) bad("a_unexpected_out", out_data_a);
                else begin
                    e = q_a.pop_front();
                    chk("a_data", out_data_a, e.val);
                    chk("a_last", out_last_a, e.last);
                end
            end else if (out_last_a) bad("a_stray_last", 1);
            if (out_valid_b) begin
                if (q_b.size() == 0) bad("b_unexpected_out", out_data_b);
                else begin
                    e = q_b.pop_front();
                    chk("b_data", out_data_b, e.val);
                    chk("b_last", out_last_b, e.last);
                end
            end else if (out_last_b) bad("b_stray_last", 1);
            if (out_valid_c) begin
                if (q_c.size() == 0) bad("c_unexpected_out", out_data_c);
                else begin
                    e = q_c.pop_front();
                    chk("c_data", out_data_c, e.val);
                    chk("c_last", out_last_c, e.last);
                end
            end else if (out_last_c) bad("c_stray_last", 1);
        end
    end

    task automatic reset_dut();
        rst_n = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_a", out_valid_a, 0);
        chk("rst_last_a",  out_last_a, 0);
        chk("rst_data_a",  out_data_a, 0);
        chk("rst_ready_a", in_ready_a, 1);
        chk("rst_valid_b", out_valid_b, 0);
        chk("rst_ready_c", in_ready_c, 1);
        rst_n = 1'b1;
    endtask

    task automatic write_coef(input logic [4:0] a, input logic signed [5:0] d);
        tap_we = 1'b1; tap_addr = a; tap_wdata = d;
        @(posedge clk); #1;
        tap_we = 1'b0;
    endtask

    task automatic load_coefs();
        write_coef(5'd0, 6'sd1);
        write_coef(5'd1, 6'sd4);
        write_coef(5'd2, 6'sd8);
    endtask

    // One sample on the shared 5-tap inputs, optionally with a same-cycle coefficient write
    task automatic send(input logic b, input logic l, input int e,
                        input logic we, input logic [4:0] wa, input logic signed [5:0] wd);
        int n = 0;
        while (!in_ready_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) bad("ready_timeout", n);
        in_valid = 1'b1; in_bit = b; in_last = l;
        tap_we = we; tap_addr = wa; tap_wdata = wd;
        push_exp(e, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; tap_we = 1'b0;
    endtask

    task automatic send_c(input logic b, input logic l, input int e);
        exp_t t;
        c_in_valid = 1'b1; c_in_bit = b; c_in_last = l;
        t.val = 16'(e); t.last = l; q_c.push_back(t);
        @(posedge clk); #1;
        c_in_valid = 1'b0; c_in_last = 1'b0;
        chk("c_ready_after_accept", in_ready_c, 1);
    endtask

    task automatic settle();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (n >= 300) begin
            bad("drain_timeout", q_a.size());
            q_a.delete(); q_b.delete(); q_c.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp2[9] = '{-16, -8, 8, 16, 18, 18, 18, 18, 18};
        #2;
        reset_dut();
        load_coefs();

        // single bit 1 from cleared history, then its 2-sample tail
        send(1'b1, 1'b1, -16, 1'b0, 5'd0, 6'sd0);
        push_exp(-8, 1'b0);
        push_exp(8, 1'b1);
        settle();

        // seven 1s; a stray in_last without in_valid first
        reset_dut();
        load_coefs();
        in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
        ready_low_a = 0;
        for (int i = 0; i < 7; i++) send(1'b1, (i == 6), exp2[i], 1'b0, 5'd0, 6'sd0);
        push_exp(exp2[7], 1'b0);
        push_exp(exp2[8], 1'b1);
        settle();
        chk("t2_ready_low_cycles", ready_low_a, 2);

        // all zeros: steady -18, exercises negative width reduction
        reset_dut();
        load_coefs();
        for (int i = 0; i < 5; i++) send(1'b0, (i == 4), -18, 1'b0, 5'd0, 6'sd0);
        push_exp(-18, 1'b0);
        push_exp(-18, 1'b1);
        settle();

        // coefficient writes coincident with samples
        reset_dut();
        load_coefs();
        send(1'b1, 1'b0, -16, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b0, -8, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b0, 8, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b0, 16, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b0, 18, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b0, 18, 1'b1, 5'd2, 6'sd0);
        send(1'b1, 1'b0, 10, 1'b1, 5'd3, 6'sd7);
        send(1'b1, 1'b1, 10, 1'b0, 5'd0, 6'sd0);
        push_exp(10, 1'b0);
        push_exp(10, 1'b1);
        settle();

        // reset in the middle of the flush
        reset_dut();
        load_coefs();
        send(1'b1, 1'b0, -16, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b0, -8, 1'b0, 5'd0, 6'sd0);
        send(1'b1, 1'b1, 8, 1'b0, 5'd0, 6'sd0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete();
        #1;
        chk("midrst_valid", out_valid_a, 0);
        chk("midrst_last",  out_last_a, 0);
        chk("midrst_data",  out_data_a, 0);
        chk("midrst_ready", in_ready_a, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_coefs();
        send(1'b1, 1'b1, -16, 1'b0, 5'd0, 6'sd0);
        push_exp(-8, 1'b0);
        push_exp(8, 1'b1);
        settle();

        // single-tap instance: no flush, out_last on the sample itself
        write_coef(5'd0, 6'sd5);
        ready_low_c = 0;
        send_c(1'b0, 1'b1, -5);
        send_c(1'b1, 1'b0, 5);
        send_c(1'b1, 1'b1, 5);
        settle();
        chk("c_ready_low_cycles", ready_low_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
